// File: rtl/inst_encoder_pkg.sv
// Shared RV32I constants, field bundle and encoder state type.
// The encoder is the inverse of the decoder, so both sides must agree on these encodings.
package inst_encoder_pkg;

    localparam logic [2:0] INSTRUCTION_TYPE_R = 3'd0;
    localparam logic [2:0] INSTRUCTION_TYPE_I = 3'd1;
    localparam logic [2:0] INSTRUCTION_TYPE_S = 3'd2;
    localparam logic [2:0] INSTRUCTION_TYPE_U = 3'd3;
    localparam logic [2:0] INSTRUCTION_TYPE_B = 3'd4;
    localparam logic [2:0] INSTRUCTION_TYPE_J = 3'd5;

    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
    localparam logic [6:0] OPCODE_JALR   = 7'b1100111;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [2:0] F3_SLLI    = 3'b001;
    localparam logic [2:0] F3_SRLI    = 3'b101;
    localparam logic [2:0] F3_BEQ     = 3'b000;
    localparam logic [2:0] F3_BNE     = 3'b001;
    localparam logic [2:0] F3_LW      = 3'b010;
    localparam logic [2:0] F3_SW      = 3'b010;

    localparam logic [31:0] NOP_WORD = 32'h00000013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } enc_state_e;

    typedef struct packed {
        logic [2:0]  inst_type;
        logic [6:0]  opcode;
        logic [2:0]  funct_3;
        logic [6:0]  funct_7;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [11:0] imm;
        logic [19:0] imm_U_J;
    } inst_fields_t;

endpackage

// File: rtl/inst_encoder_if.sv
// Loader-side bundle: burst control, field bundle handshake and imem write port.
interface inst_encoder_if #(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 16
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [LEN_W-1:0]  len;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        inst_type;
    logic [6:0]        opcode;
    logic [2:0]        funct_3;
    logic [6:0]        funct_7;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [4:0]        rd;
    logic [11:0]       imm;
    logic [19:0]       imm_U_J;
    logic              imem_wr_en;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output start, base_addr, len, in_valid, inst_type, opcode, funct_3, funct_7,
               rs1, rs2, rd, imm, imm_U_J,
        input  in_ready, imem_wr_en, imem_addr, imem_wdata, busy, done, err
    );

    modport slave (
        input  start, base_addr, len, in_valid, inst_type, opcode, funct_3, funct_7,
               rs1, rs2, rd, imm, imm_U_J,
        output in_ready, imem_wr_en, imem_addr, imem_wdata, busy, done, err
    );
endinterface

// File: rtl/inst_encoder_pack.sv
// Combinational field-to-word packer; B/J immediates use the decoder's packed layout,
// not the raw ISA immediate, so imm bit k is not instruction bit k.
module inst_pack
    import inst_encoder_pkg::*;
(
    input  inst_fields_t i_fields,
    output logic [31:0]  o_word,
    output logic         o_illegal
);
    logic w_shift;

    assign w_shift = (i_fields.opcode == OPCODE_OP_IMM) &&
                     ((i_fields.funct_3 == F3_SLLI) || (i_fields.funct_3 == F3_SRLI));

    always_comb begin
        o_word    = NOP_WORD;
        o_illegal = 1'b0;
        case (i_fields.inst_type)
            INSTRUCTION_TYPE_R:
                o_word = {i_fields.funct_7, i_fields.rs2, i_fields.rs1, i_fields.funct_3,
                          i_fields.rd, i_fields.opcode};
            INSTRUCTION_TYPE_I:
                if (w_shift)
                    o_word = {i_fields.funct_7, i_fields.imm[4:0], i_fields.rs1,
                              i_fields.funct_3, i_fields.rd, i_fields.opcode};
                else
                    o_word = {i_fields.imm, i_fields.rs1, i_fields.funct_3,
                              i_fields.rd, i_fields.opcode};
            INSTRUCTION_TYPE_S:
                o_word = {i_fields.imm[11:5], i_fields.rs2, i_fields.rs1, i_fields.funct_3,
                          i_fields.imm[4:0], i_fields.opcode};
            INSTRUCTION_TYPE_B:
                o_word = {i_fields.imm[11], i_fields.imm[9:4], i_fields.rs2, i_fields.rs1,
                          i_fields.funct_3, i_fields.imm[3:0], i_fields.imm[10],
                          i_fields.opcode};
            INSTRUCTION_TYPE_U:
                o_word = {i_fields.imm_U_J, i_fields.rd, i_fields.opcode};
            INSTRUCTION_TYPE_J:
                o_word = {i_fields.imm_U_J[19], i_fields.imm_U_J[9:0], i_fields.imm_U_J[10],
                          i_fields.imm_U_J[18:11], i_fields.rd, i_fields.opcode};
            default:
                o_illegal = 1'b1;
        endcase
    end
endmodule

// File: rtl/inst_encoder.sv
// Burst encoder: accepts len field bundles after start and writes one encoded word
// per accepted bundle to consecutive imem addresses, one cycle after the handshake.
module inst_encoder
    import inst_encoder_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic           clk,
    input  logic           reset,
    inst_encoder_if.slave  bus
);
    enc_state_e        r_state;
    logic [ADDR_W-1:0] r_ptr;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_cnt;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic              r_err;

    inst_fields_t      w_fields;
    logic [31:0]       w_word;
    logic              w_illegal;
    logic              w_hs;
    logic [LEN_W-1:0]  w_cnt_nxt;

    always_comb begin
        w_fields           = '0;
        w_fields.inst_type = bus.inst_type;
        w_fields.opcode    = bus.opcode;
        w_fields.funct_3   = bus.funct_3;
        w_fields.funct_7   = bus.funct_7;
        w_fields.rs1       = bus.rs1;
        w_fields.rs2       = bus.rs2;
        w_fields.rd        = bus.rd;
        w_fields.imm       = bus.imm;
        w_fields.imm_U_J   = bus.imm_U_J;
    end

    inst_pack u_pack (
        .i_fields  (w_fields),
        .o_word    (w_word),
        .o_illegal (w_illegal)
    );

    assign w_hs      = bus.in_valid && (r_state == RUN);
    assign w_cnt_nxt = r_cnt + LEN_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_wr_en <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_wr_en <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_ptr   <= bus.base_addr & ~ADDR_W'(3);
                        r_len   <= bus.len;
                        r_cnt   <= '0;
                        r_err   <= 1'b0;
                        r_state <= (bus.len == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (w_hs) begin
                        r_wr_en <= 1'b1;
                        r_addr  <= r_ptr;
                        r_wdata <= w_word;
                        r_ptr   <= r_ptr + ADDR_W'(4);
                        r_cnt   <= w_cnt_nxt;
                        if (w_illegal)
                            r_err <= 1'b1;
                        if (w_cnt_nxt == r_len)
                            r_state <= DONE;
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready   = (r_state == RUN);
    assign bus.busy       = (r_state == RUN);
    assign bus.done       = (r_state == DONE);
    assign bus.imem_wr_en = r_wr_en;
    assign bus.imem_addr  = r_addr;
    assign bus.imem_wdata = r_wdata;
    assign bus.err        = r_err;
endmodule

// File: tb/tb_inst_encoder.sv
// Scoreboard bench for inst_encoder: stimulus pushes expected writes, a negedge monitor checks them.
module tb_inst_encoder;
    import inst_encoder_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    inst_encoder_if #(.ADDR_W(32), .LEN_W(16)) bus ();

    inst_encoder #(.ADDR_W(32), .LEN_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        last;
    } exp_t;

    exp_t        q[$];
    int          tests = 0;
    int          fails = 0;
    int          exp_done_only = 0;
    logic [31:0] m_ptr;
    int          m_rem;
    logic        m_err;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference encoder built from bit positions with plain arithmetic.
    function automatic logic [31:0] ref_word(input inst_fields_t f);
        int unsigned op, f3, f7, r1, r2, rd, im, uj;
        op = f.opcode; f3 = f.funct_3; f7 = f.funct_7;
        r1 = f.rs1; r2 = f.rs2; rd = f.rd; im = f.imm; uj = f.imm_U_J;
        case (f.inst_type)
            INSTRUCTION_TYPE_R: return f7 * (2**25) + r2 * (2**20) + r1 * (2**15) + f3 * (2**12) + rd * 128 + op;
            INSTRUCTION_TYPE_I:
                if (op == 32'h13 && (f3 == 1 || f3 == 5))
                    return f7 * (2**25) + (im % 32) * (2**20) + r1 * (2**15) + f3 * (2**12) + rd * 128 + op;
                else
                    return im * (2**20) + r1 * (2**15) + f3 * (2**12) + rd * 128 + op;
            INSTRUCTION_TYPE_S: return (im / 32) * (2**25) + r2 * (2**20) + r1 * (2**15) + f3 * (2**12) + (im % 32) * 128 + op;
            INSTRUCTION_TYPE_B: return (im / 2048) * (2**31) + ((im / 16) % 64) * (2**25) + r2 * (2**20) + r1 * (2**15)
                                       + f3 * (2**12) + (im % 16) * 256 + ((im / 1024) % 2) * 128 + op;
            INSTRUCTION_TYPE_U: return uj * (2**12) + rd * 128 + op;
            INSTRUCTION_TYPE_J: return (uj / 524288) * (2**31) + (uj % 1024) * (2**21) + ((uj / 1024) % 2) * (2**20)
                                       + ((uj / 2048) % 256) * (2**12) + rd * 128 + op;
            default: return 32'h00000013;
        endcase
    endfunction

    function automatic inst_fields_t mk(input logic [2:0] t, input logic [6:0] op, input logic [2:0] f3,
                                        input logic [6:0] f7, input logic [4:0] r1, input logic [4:0] r2,
                                        input logic [4:0] rd, input logic [11:0] im, input logic [19:0] uj);
        inst_fields_t f;
        f.inst_type = t; f.opcode = op; f.funct_3 = f3; f.funct_7 = f7;
        f.rs1 = r1; f.rs2 = r2; f.rd = rd; f.imm = im; f.imm_U_J = uj;
        return f;
    endfunction

    function automatic inst_fields_t rand_fields();
        logic [6:0] ops [9];
        inst_fields_t f;
        ops = '{OPCODE_OP, OPCODE_OP_IMM, OPCODE_LOAD, OPCODE_STORE, OPCODE_BRANCH,
                OPCODE_LUI, OPCODE_AUIPC, OPCODE_JAL, OPCODE_JALR};
        f.inst_type = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
        f.opcode    = ops[$urandom_range(0, 8)];
        f.funct_3   = 3'($urandom);
        f.funct_7   = 7'($urandom);
        f.rs1 = 5'($urandom); f.rs2 = 5'($urandom); f.rd = 5'($urandom);
        f.imm       = 12'($urandom);
        f.imm_U_J   = 20'($urandom);
        return f;
    endfunction

    task automatic drive(input inst_fields_t f);
        bus.inst_type = f.inst_type; bus.opcode = f.opcode; bus.funct_3 = f.funct_3;
        bus.funct_7 = f.funct_7; bus.rs1 = f.rs1; bus.rs2 = f.rs2; bus.rd = f.rd;
        bus.imm = f.imm; bus.imm_U_J = f.imm_U_J;
    endtask

    task automatic do_start(input logic [31:0] base, input logic [15:0] len);
        bus.start = 1'b1; bus.base_addr = base; bus.len = len;
        m_ptr = base & ~32'd3; m_rem = int'(len); m_err = 1'b0;
        if (len == 0) exp_done_only++;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic stray_start(input logic [31:0] base, input logic [15:0] len);
        bus.start = 1'b1; bus.base_addr = base; bus.len = len;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Inputs change at negedge; if in_ready is high now, the next posedge is the handshake.
    task automatic send(input inst_fields_t f, input logic [31:0] w);
        exp_t e;
        int n = 0;
        drive(f);
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            chk("send_ready_timeout", 32'(bus.in_ready), 32'd1);
            bus.in_valid = 1'b0;
            return;
        end
        e.addr = m_ptr; e.data = w; e.last = (m_rem == 1);
        q.push_back(e);
        if (f.inst_type > 3'd5) m_err = 1'b1;
        m_ptr = m_ptr + 32'd4;
        m_rem--;
        @(negedge clk);
    endtask

    task automatic end_burst();
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("idle_after_burst_busy", 32'(bus.busy), 32'd0);
    endtask

    always @(negedge clk) begin
        if (bus.imem_wr_en === 1'b1) begin
            if (q.size() == 0) begin
                chk("unexpected_write", bus.imem_addr, 32'hxxxx_xxxx);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("wr_addr", bus.imem_addr, e.addr);
                chk("wr_data", bus.imem_wdata, e.data);
                chk("done_with_last", 32'(bus.done), 32'(e.last));
            end
        end else if (bus.done === 1'b1) begin
            chk("done_only_expected", 32'(exp_done_only > 0), 32'd1);
            if (exp_done_only > 0) exp_done_only--;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        inst_fields_t f;
        reset = 1'b1;
        bus.start = 1'b0; bus.base_addr = '0; bus.len = '0; bus.in_valid = 1'b0;
        drive('0);
        m_ptr = '0; m_rem = 0; m_err = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(bus.in_ready), 0);
        chk("rst_wr_en", 32'(bus.imem_wr_en), 0);
        chk("rst_addr", bus.imem_addr, 0);
        chk("rst_wdata", bus.imem_wdata, 0);
        chk("rst_busy_done_err", {29'd0, bus.busy, bus.done, bus.err}, 0);
        reset = 1'b0;
        @(negedge clk);

        // R single
        do_start(32'h100, 16'd1);
        chk("busy_in_run", 32'(bus.busy), 1);
        send(mk(INSTRUCTION_TYPE_R, OPCODE_OP, 3'd0, 7'd0, 5'd13, 5'd5, 5'd13, 12'd0, 20'd0), 32'h005686b3);
        chk("ready_low_after_last", 32'(bus.in_ready), 0);
        end_burst();

        // I then shift, back to back
        do_start(32'h200, 16'd2);
        send(mk(INSTRUCTION_TYPE_I, OPCODE_OP_IMM, 3'd0, 7'd0, 5'd2, 5'd0, 5'd2, 12'hFE0, 20'd0), 32'hfe010113);
        send(mk(INSTRUCTION_TYPE_I, OPCODE_OP_IMM, F3_SRLI, 7'b0100000, 5'd18, 5'd0, 5'd18, 12'd2, 20'd0), 32'h40295913);
        end_burst();

        // B, J, S
        do_start(32'h300, 16'd3);
        send(mk(INSTRUCTION_TYPE_B, OPCODE_BRANCH, 3'd0, 7'd0, 5'd10, 5'd13, 5'd0, 12'h014, 20'd0), 32'h02d50463);
        send(mk(INSTRUCTION_TYPE_J, OPCODE_JAL, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 12'd0, 20'h000CE), 32'h19c000ef);
        send(mk(INSTRUCTION_TYPE_S, OPCODE_STORE, F3_SW, 7'd0, 5'd10, 5'd8, 5'd0, 12'd0, 20'd0), 32'h00852023);
        end_burst();

        // Illegal in the middle, stray start ignored mid-burst
        do_start(32'h400, 16'd3);
        send(mk(INSTRUCTION_TYPE_U, OPCODE_LUI, 3'd0, 7'd0, 5'd0, 5'd0, 5'd5, 12'd0, 20'h12345), 32'h123452b7);
        send(mk(3'b111, OPCODE_OP, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 12'd0, 20'd0), 32'h00000013);
        bus.in_valid = 1'b0;
        stray_start(32'h9000, 16'd9);
        chk("err_sticky_after_stray", 32'(bus.err), 1);
        chk("busy_after_stray", 32'(bus.busy), 1);
        send(mk(INSTRUCTION_TYPE_R, OPCODE_OP, 3'd7, 7'd0, 5'd1, 5'd2, 5'd3, 12'd0, 20'd0), 32'h0020f1b3);
        end_burst();
        chk("err_held_in_idle", 32'(bus.err), 1);

        // Address wrap, also clears err
        do_start(32'hFFFF_FFF8, 16'd3);
        chk("err_cleared_by_start", 32'(bus.err), 0);
        for (int i = 0; i < 3; i++) begin
            f = rand_fields();
            f.inst_type = INSTRUCTION_TYPE_R;
            send(f, ref_word(f));
        end
        end_burst();

        // len 0: done only
        do_start(32'h500, 16'd0);
        chk("len0_done", 32'(bus.done), 1);
        chk("len0_ready", 32'(bus.in_ready), 0);
        @(negedge clk);

        // Randomized bursts with gaps
        for (int b = 0; b < 12; b++) begin
            int len;
            len = $urandom_range(1, 6);
            do_start($urandom, 16'(len));
            for (int i = 0; i < len; i++) begin
                bus.in_valid = 1'b0;
                repeat ($urandom_range(0, 2)) @(negedge clk);
                f = rand_fields();
                send(f, ref_word(f));
            end
            end_burst();
            chk("rand_err", 32'(bus.err), 32'(m_err));
        end

        // Reset mid-burst drops everything
        do_start(32'h2000, 16'd5);
        for (int i = 0; i < 2; i++) begin
            f = rand_fields();
            send(f, ref_word(f));
        end
        f = rand_fields();
        f.inst_type = 3'b110;
        drive(f);
        bus.in_valid = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_wr_en", 32'(bus.imem_wr_en), 0);
        chk("rst_mid_busy", 32'(bus.busy), 0);
        chk("rst_mid_err", 32'(bus.err), 0);
        chk("rst_mid_addr", bus.imem_addr, 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_rst_ready", 32'(bus.in_ready), 0);
        bus.in_valid = 1'b0;

        repeat (3) @(negedge clk);
        chk("queue_drained", 32'(q.size()), 0);
        chk("done_only_drained", 32'(exp_done_only), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
